uart_wrapper: RTL and testbench

- Command-side serial front end of the logic analyzer.
- Deserializes two 8N1 UART bytes on RX into one 16-bit command, high byte first, and presents it to cmd_cfg with a ready/clear handshake.
- Serializes a single 8-bit response byte from cmd_cfg onto TX and pulses a completion strobe.
- Sits between the host link pins and cmd_cfg.

---
 rtl/uart_wrapper_pkg.sv | 26 ++
 rtl/uart_byte_rx.sv | 103 ++++++++++
 rtl/uart_wrapper.sv | 149 ++++++++++++++
 tb/tb_uart_wrapper.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wrapper_pkg.sv
// Shared state encodings and defaults for the command-link UART wrapper.
// No logic here; imported by the receiver and the wrapper top.
package uart_wrapper_pkg;

    localparam int DEFAULT_BAUD_DIV = 2604;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic {
        ASM_HIGH,
        ASM_LOW
    } asm_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: byte_done pulses one cycle at mid stop bit, ~9.5 bit times after start edge.
// No backpressure: rx_byte is only valid in the byte_done cycle and must be taken then.
module uart_byte_rx
    import uart_wrapper_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    rx_state_t       state;
    rx_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_nxt;
    logic [7:0]      shift;
    logic [7:0]      shift_nxt;
    logic            done;
    logic            done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            done    <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            done    <= done_nxt;
        end
    end

    // Start bit is re-checked at its midpoint; later samples then land mid-bit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        done_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s2) begin
                    state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s2, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = RX_IDLE;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign byte_done = done;
    assign rx_byte   = shift;

endmodule

// File: rtl/uart_wrapper.sv
// Host-link UART front end: two RX bytes -> 16-bit cmd (cmd_rdy one cycle after 2nd byte_done); one resp byte -> TX frame.
// No backpressure: cmd_rdy is a flag cleared by clr_cmd_rdy or a new first byte; send_resp is dropped unless TX is idle.
module uart_wrapper
    import uart_wrapper_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [15:0] cmd,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_sent,
    output logic        TX
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic       byte_done;
    logic [7:0] rx_byte;

    uart_byte_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    asm_state_t asm_state;
    asm_state_t asm_nxt;

    always_comb begin
        asm_nxt = asm_state;
        if (byte_done) begin
            asm_nxt = (asm_state == ASM_HIGH) ? ASM_LOW : ASM_HIGH;
        end
    end

    // A completing second byte sets cmd_rdy even if clr_cmd_rdy arrives the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state <= ASM_HIGH;
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
        end else begin
            asm_state <= asm_nxt;
            if (byte_done && asm_state == ASM_HIGH) begin
                cmd[15:8] <= rx_byte;
                cmd_rdy   <= 1'b0;
            end else if (byte_done && asm_state == ASM_LOW) begin
                cmd[7:0]  <= rx_byte;
                cmd_rdy   <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy   <= 1'b0;
            end
        end
    end

    tx_state_t     tx_state;
    tx_state_t     tx_state_nxt;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] tx_cnt_nxt;
    logic [2:0]    tx_bit;
    logic [2:0]    tx_bit_nxt;
    logic [7:0]    tx_shift;
    logic [7:0]    tx_shift_nxt;
    logic          tx_line_nxt;
    logic          sent_nxt;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                if (send_resp) begin
                    tx_shift_nxt = resp;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_bit_nxt   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                tx_cnt_nxt   = '0;
            end
        endcase
    end

    // Line level and completion strobe are decoded from next-state so both registers line up with tx_state.
    always_comb begin
        tx_line_nxt = 1'b1;
        case (tx_state_nxt)
            TX_START: tx_line_nxt = 1'b0;
            TX_DATA:  tx_line_nxt = tx_shift_nxt[0];
            default:  tx_line_nxt = 1'b1;
        endcase
        sent_nxt = (tx_state_nxt == TX_STOP) && (tx_cnt_nxt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_shift  <= tx_shift_nxt;
            TX        <= tx_line_nxt;
            resp_sent <= sent_nxt;
        end
    end

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed plus randomized bench for uart_wrapper at BAUD_DIV=8.
// Expected commands come from a history of bytes sent; expected TX from frame bit lists.
module tb_uart_wrapper;

    localparam int B = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;
    logic        TX;

    int n_assert = 0;
    int n_fail   = 0;
    int sent_cnt = 0;

    logic [7:0] rx_hist[$];
    bit         m_clr;

    uart_wrapper #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .TX          (TX)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (resp_sent === 1'b1) sent_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the latest complete pair forms cmd; a lone first byte replaces only the high half.
    function automatic logic [15:0] exp_cmd();
        int n = rx_hist.size();
        if (n == 0) return 16'h0000;
        if (n % 2 == 0) return {rx_hist[n-2], rx_hist[n-1]};
        return {rx_hist[n-1], (n >= 2) ? rx_hist[n-2] : 8'h00};
    endfunction

    function automatic logic exp_rdy();
        int n = rx_hist.size();
        return (n > 0) && (n % 2 == 0) && !m_clr;
    endfunction

    task automatic check_cmd(input string tag);
        chk({tag, "_cmd"}, cmd, exp_cmd());
        chk({tag, "_rdy"}, {15'd0, cmd_rdy}, {15'd0, exp_rdy()});
    endtask

    task automatic rx_frame(input logic [7:0] b);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic rx_byte_model(input logic [7:0] b);
        rx_frame(b);
        rx_hist.push_back(b);
        if (rx_hist.size() % 2 == 0) m_clr = 0;
    endtask

    task automatic tx_kick(input logic [7:0] b);
        send_resp = 1'b1;
        resp      = b;
        @(negedge clk);
        send_resp = 1'b0;
        resp      = 8'h00;
    endtask

    // Called at the first start-bit cycle; walks start, 8 data bits LSB first, stop.
    task automatic tx_check(input logic [7:0] b, input string tag);
        logic exp_bits[10];
        bit   rs_ok = 1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        exp_bits[9] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic seen = exp_bits[k];
            for (int c = 0; c < B; c++) begin
                if (TX !== exp_bits[k]) seen = TX;
                if (resp_sent !== ((k == 9) && (c == B - 1))) rs_ok = 0;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, k), {15'd0, seen}, {15'd0, exp_bits[k]});
        end
        chk({tag, "_resp_sent_timing"}, {15'd0, rs_ok}, 16'd1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rx_hist.delete();
        m_clr = 0;
        chk({tag, "_cmd"}, cmd, 16'h0000);
        chk({tag, "_rdy"}, {15'd0, cmd_rdy}, 16'd0);
        chk({tag, "_tx"}, {15'd0, TX}, 16'd1);
        chk({tag, "_resp_sent"}, {15'd0, resp_sent}, 16'd0);
        rst = 1'b0;
    endtask

    initial begin
        int          base;
        logic [7:0]  b0, b1;

        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
        m_clr = 0;
        repeat (3) @(negedge clk);
        do_reset("reset");
        repeat (2) @(negedge clk);

        // Basic command and acknowledge.
        rx_byte_model(8'h41);
        rx_byte_model(8'h01);
        check_cmd("cmd_4101");
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        m_clr = 1;
        check_cmd("clr");

        // Response frame.
        base = sent_cnt;
        tx_kick(8'hA5);
        tx_check(8'hA5, "txA5");
        repeat (3) @(negedge clk);
        chk("txA5_pulses", 16'(sent_cnt - base), 16'd1);

        // Short low glitch is rejected.
        RX = 1'b0;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        repeat (4 * B) @(negedge clk);
        check_cmd("glitch");
        rx_byte_model(8'h80);
        rx_byte_model(8'h00);
        check_cmd("cmd_8000");

        // Uncleared command overtaken by a new first byte.
        rx_byte_model(8'h10);
        rx_byte_model(8'h01);
        check_cmd("cmd_1001");
        rx_byte_model(8'h07);
        check_cmd("first_07");
        rx_byte_model(8'h55);
        check_cmd("cmd_0755");

        // TX busy: a second request is ignored while RX runs concurrently.
        base = sent_cnt;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        tx_kick(8'hEE);
        fork
            begin
                rx_byte_model(b0);
                rx_byte_model(b1);
            end
            tx_check(8'hEE, "txEE");
            begin
                repeat (30) @(negedge clk);
                send_resp = 1'b1;
                resp      = 8'h00;
                @(negedge clk);
                send_resp = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("txEE_pulses", 16'(sent_cnt - base), 16'd1);
        chk("txEE_idle", {15'd0, TX}, 16'd1);
        check_cmd("concurrent_rx");

        // Randomized commands and back-to-back responses.
        for (int it = 0; it < 4; it++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            rx_byte_model(b0);
            check_cmd($sformatf("rand%0d_hi", it));
            rx_byte_model(b1);
            check_cmd($sformatf("rand%0d_pair", it));
            if ($urandom_range(0, 1) == 1) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                m_clr = 1;
                check_cmd($sformatf("rand%0d_clr", it));
            end
            base = sent_cnt;
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            tx_kick(b0);
            tx_check(b0, $sformatf("rand%0d_txa", it));
            tx_kick(b1);
            tx_check(b1, $sformatf("rand%0d_txb", it));
            repeat (2) @(negedge clk);
            chk($sformatf("rand%0d_pulses", it), 16'(sent_cnt - base), 16'd2);
        end

        // Reset mid-command and mid-frame.
        rx_byte_model(8'h33);
        tx_kick(8'h00);
        repeat (20) @(negedge clk);
        base = sent_cnt;
        do_reset("midreset");
        repeat (12 * B) @(negedge clk);
        chk("midreset_no_pulse", 16'(sent_cnt - base), 16'd0);
        chk("midreset_tx_idle", {15'd0, TX}, 16'd1);
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        rx_byte_model(b0);
        rx_byte_model(b1);
        check_cmd("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
